// File: rtl/vote_tally_n_if.sv
`default_nettype none
// ============================================================================
// Module      : vote_tally_n_if
// Description : Front-panel control/display bundle for the ballot counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface vote_tally_n_if #(
    parameter int N_CAND = 15,
    parameter int CNT_W  = 12
);
    localparam int SEL_W = $clog2(N_CAND + 1);

    logic             Open;
    logic             Close;
    logic             Clear;
    logic             Ballot;
    logic             Total;
    logic             Result;
    logic [SEL_W-1:0] IN;
    logic [CNT_W-1:0] out;
    logic [SEL_W-1:0] cand_out;
    logic [SEL_W-1:0] winner;
    logic             tie;
    logic             vote_ack;
    logic             vote_err;
    logic             sat;
    logic             busy;
    logic             polls_open;

    modport master (
        output Open, Close, Clear, Ballot, Total, Result, IN,
        input  out, cand_out, winner, tie, vote_ack, vote_err, sat, busy, polls_open
    );

    modport slave (
        input  Open, Close, Clear, Ballot, Total, Result, IN,
        output out, cand_out, winner, tie, vote_ack, vote_err, sat, busy, polls_open
    );
endinterface
`default_nettype wire

// File: rtl/vote_tally_n.sv
`default_nettype none
// ============================================================================
// Module      : vote_tally_n
// Description : Parametrised saturating ballot counter with winner/tie scan.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_tally_n #(
    parameter int N_CAND = 15,
    parameter int CNT_W  = 12
) (
    input  wire logic         clk,
    input  wire logic         Power,
    vote_tally_n_if.slave     bus
);
    localparam int               SEL_W     = $clog2(N_CAND + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [SEL_W-1:0] C_FIRST   = SEL_W'(1);
    localparam logic [SEL_W-1:0] C_LAST    = SEL_W'(N_CAND);

    typedef enum logic [2:0] {
        S_OPEN   = 3'd0,
        S_ARMED  = 3'd1,
        S_SCAN   = 3'd2,
        S_RESULT = 3'd3,
        S_CLEAR  = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt [1:N_CAND];
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_max;
    logic [SEL_W-1:0] r_idx;
    logic [CNT_W-1:0] r_out;
    logic [SEL_W-1:0] r_cand;
    logic [SEL_W-1:0] r_winner;
    logic             r_tie;
    logic             r_ack;
    logic             r_err;
    logic             r_sat;
    logic             r_res_q;

    logic             w_in_valid;
    logic             w_in_err;
    logic             w_step;
    logic [CNT_W-1:0] w_vote_cnt;
    logic [CNT_W-1:0] w_vote_inc;
    logic [CNT_W-1:0] w_total_inc;
    logic [CNT_W-1:0] w_scan_cnt;
    logic [SEL_W-1:0] w_next_cand;
    logic [CNT_W-1:0] w_step_cnt;

    assign w_in_valid  = (bus.IN != '0) && (int'(bus.IN) <= N_CAND);
    assign w_in_err    = (int'(bus.IN) > N_CAND);
    assign w_step      = bus.Result & ~r_res_q;
    assign w_next_cand = (r_cand == C_LAST) ? C_FIRST : r_cand + C_FIRST;
    assign w_vote_inc  = (w_vote_cnt == C_CNT_MAX) ? w_vote_cnt : w_vote_cnt + CNT_W'(1);
    assign w_total_inc = (r_total == C_CNT_MAX) ? r_total : r_total + CNT_W'(1);

    // Counter read muxes for the voted code, the scan index and the next result
    always_comb begin
        w_vote_cnt = '0;
        w_scan_cnt = '0;
        w_step_cnt = '0;
        for (int k = 1; k <= N_CAND; k++) begin
            if (bus.IN == SEL_W'(k))
                w_vote_cnt = r_cnt[k];
            if (r_idx == SEL_W'(k))
                w_scan_cnt = r_cnt[k];
            if (w_next_cand == SEL_W'(k))
                w_step_cnt = r_cnt[k];
        end
    end

    always_ff @(posedge clk) begin
        if (Power) begin
            r_state  <= S_OPEN;
            for (int k = 1; k <= N_CAND; k++)
                r_cnt[k] <= '0;
            r_total  <= '0;
            r_max    <= '0;
            r_idx    <= '0;
            r_out    <= '0;
            r_cand   <= '0;
            r_winner <= '0;
            r_tie    <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_sat    <= 1'b0;
            r_res_q  <= 1'b0;
        end else begin
            r_res_q <= bus.Result;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_OPEN: begin
                    r_out <= bus.Total ? r_total : '0;
                    if (bus.Clear) begin
                        r_state <= S_CLEAR;
                    end else if (bus.Close) begin
                        r_state  <= S_SCAN;
                        r_idx    <= C_FIRST;
                        r_max    <= '0;
                        r_winner <= '0;
                        r_tie    <= 1'b0;
                    end else if (bus.Ballot) begin
                        r_state <= S_ARMED;
                    end
                end

                S_ARMED: begin
                    if (bus.Clear) begin
                        r_state <= S_CLEAR;
                    end else if (w_in_valid) begin
                        for (int k = 1; k <= N_CAND; k++)
                            if (bus.IN == SEL_W'(k))
                                r_cnt[k] <= w_vote_inc;
                        r_total <= w_total_inc;
                        r_sat   <= r_sat | (w_vote_inc == C_CNT_MAX) | (w_total_inc == C_CNT_MAX);
                        r_ack   <= 1'b1;
                        r_state <= S_OPEN;
                    end else if (w_in_err) begin
                        r_err <= 1'b1;
                    end
                end

                S_SCAN: begin
                    if (bus.Clear) begin
                        r_state <= S_CLEAR;
                    end else begin
                        // Strict '>' keeps the lowest index as winner on ties
                        if (w_scan_cnt > r_max) begin
                            r_max    <= w_scan_cnt;
                            r_winner <= r_idx;
                            r_tie    <= 1'b0;
                        end else if ((w_scan_cnt == r_max) && (r_max != '0)) begin
                            r_tie <= 1'b1;
                        end
                        if (r_idx == C_LAST) begin
                            r_state <= S_RESULT;
                            r_cand  <= C_FIRST;
                            r_out   <= r_cnt[1];
                        end else begin
                            r_idx <= r_idx + C_FIRST;
                        end
                    end
                end

                S_RESULT: begin
                    if (bus.Clear) begin
                        r_state <= S_CLEAR;
                    end else if (!bus.Close && bus.Open) begin
                        r_state <= S_OPEN;
                    end else if (w_step) begin
                        r_cand <= w_next_cand;
                        r_out  <= w_step_cnt;
                    end
                end

                S_CLEAR: begin
                    for (int k = 1; k <= N_CAND; k++)
                        r_cnt[k] <= '0;
                    r_total  <= '0;
                    r_winner <= '0;
                    r_tie    <= 1'b0;
                    r_sat    <= 1'b0;
                    r_cand   <= '0;
                    r_out    <= '0;
                    if (!bus.Clear)
                        r_state <= S_OPEN;
                end

                default: r_state <= S_OPEN;
            endcase
        end
    end

    assign bus.out        = r_out;
    assign bus.cand_out   = r_cand;
    assign bus.winner     = r_winner;
    assign bus.tie        = r_tie;
    assign bus.vote_ack   = r_ack;
    assign bus.vote_err   = r_err;
    assign bus.sat        = r_sat;
    assign bus.busy       = (r_state == S_SCAN);
    assign bus.polls_open = (r_state == S_OPEN) || (r_state == S_ARMED);

endmodule
`default_nettype wire
